// File: rtl/axi_lite_pkg.sv
// Shared types for the IFU/LSU AXI4-Lite arbiter: response codes, FSM states, master ids.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_ADDR,
      WR_RESP
   } arb_state_e;

   typedef enum logic {
      M_IFU = 1'b0,
      M_LSU = 1'b1
   } master_e;

endpackage

// File: rtl/axi_lite_arbiter_rr_pick2.sv
// Two-requester round-robin selector: on a tie the requester that did not win last time gets the grant.
module rr_pick2
   import axi_lite_pkg::*;
(
   input  logic [1:0] req,
   input  master_e    last,
   output master_e    grant
);

   always_comb begin
      grant = M_IFU;
      if (req[1] && (!req[0] || last == M_IFU)) begin
         grant = M_LSU;
      end
   end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI4-Lite master port between the IFU (read-only) and the LSU (read/write),
// one outstanding transaction at a time, granted round-robin and held until the response completes.
//
// state   | meaning
// IDLE    | no grant; arbitrate among ifu_arvalid, lsu_arvalid, lsu_awvalid
// RD_ADDR | forward granted master's AR channel downstream
// RD_DATA | route R channel back to the granted master
// WR_ADDR | forward LSU AW and W in parallel, each until its own handshake
// WR_RESP | route B channel back to the LSU
module axi_lite_arbiter
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,

   input  logic [ADDR_W-1:0]   ifu_araddr,
   input  logic                ifu_arvalid,
   output logic                ifu_arready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic [1:0]          ifu_rresp,
   output logic                ifu_rvalid,
   input  logic                ifu_rready,

   input  logic [ADDR_W-1:0]   lsu_araddr,
   input  logic                lsu_arvalid,
   output logic                lsu_arready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic [1:0]          lsu_rresp,
   output logic                lsu_rvalid,
   input  logic                lsu_rready,
   input  logic [ADDR_W-1:0]   lsu_awaddr,
   input  logic                lsu_awvalid,
   output logic                lsu_awready,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   input  logic                lsu_wvalid,
   output logic                lsu_wready,
   output logic [1:0]          lsu_bresp,
   output logic                lsu_bvalid,
   input  logic                lsu_bready,

   output logic [ADDR_W-1:0]   arb_araddr,
   output logic                arb_arvalid,
   input  logic                arb_arready,
   input  logic [DATA_W-1:0]   arb_rdata,
   input  logic [1:0]          arb_rresp,
   input  logic                arb_rvalid,
   output logic                arb_rready,
   output logic [ADDR_W-1:0]   arb_awaddr,
   output logic                arb_awvalid,
   input  logic                arb_awready,
   output logic [DATA_W-1:0]   arb_wdata,
   output logic [DATA_W/8-1:0] arb_wstrb,
   output logic                arb_wvalid,
   input  logic                arb_wready,
   input  logic [1:0]          arb_bresp,
   input  logic                arb_bvalid,
   output logic                arb_bready
);

   arb_state_e state_q, state_d;
   master_e    grant_q, grant_d;
   master_e    last_q, last_d;
   master_e    pick;
   logic       aw_done_q, aw_done_d;
   logic       w_done_q, w_done_d;
   logic       aw_fire, w_fire;
   logic       any_req;

   assign any_req = ifu_arvalid | lsu_arvalid | lsu_awvalid;

   rr_pick2 u_pick (
      .req   ({lsu_arvalid | lsu_awvalid, ifu_arvalid}),
      .last  (last_q),
      .grant (pick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         grant_q   <= M_IFU;
         last_q    <= M_LSU;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      aw_fire     = 1'b0;
      w_fire      = 1'b0;

      ifu_arready = 1'b0;
      ifu_rdata   = '0;
      ifu_rresp   = '0;
      ifu_rvalid  = 1'b0;
      lsu_arready = 1'b0;
      lsu_rdata   = '0;
      lsu_rresp   = '0;
      lsu_rvalid  = 1'b0;
      lsu_awready = 1'b0;
      lsu_wready  = 1'b0;
      lsu_bresp   = '0;
      lsu_bvalid  = 1'b0;
      arb_araddr  = '0;
      arb_arvalid = 1'b0;
      arb_rready  = 1'b0;
      arb_awaddr  = '0;
      arb_awvalid = 1'b0;
      arb_wdata   = '0;
      arb_wstrb   = '0;
      arb_wvalid  = 1'b0;
      arb_bready  = 1'b0;

      case (state_q)
         IDLE: begin
            // Grant is registered here, so downstream valid appears one cycle after the request.
            if (any_req) begin
               grant_d = pick;
               state_d = (pick == M_LSU && lsu_awvalid) ? WR_ADDR : RD_ADDR;
            end
         end

         RD_ADDR: begin
            if (grant_q == M_IFU) begin
               arb_araddr  = ifu_araddr;
               arb_arvalid = ifu_arvalid;
               ifu_arready = arb_arready;
               if (ifu_arvalid && arb_arready) state_d = RD_DATA;
            end else begin
               arb_araddr  = lsu_araddr;
               arb_arvalid = lsu_arvalid;
               lsu_arready = arb_arready;
               if (lsu_arvalid && arb_arready) state_d = RD_DATA;
            end
         end

         RD_DATA: begin
            if (grant_q == M_IFU) begin
               ifu_rdata  = arb_rdata;
               ifu_rresp  = arb_rresp;
               ifu_rvalid = arb_rvalid;
               arb_rready = ifu_rready;
               if (arb_rvalid && ifu_rready) begin
                  last_d  = M_IFU;
                  state_d = IDLE;
               end
            end else begin
               lsu_rdata  = arb_rdata;
               lsu_rresp  = arb_rresp;
               lsu_rvalid = arb_rvalid;
               arb_rready = lsu_rready;
               if (arb_rvalid && lsu_rready) begin
                  last_d  = M_LSU;
                  state_d = IDLE;
               end
            end
         end

         WR_ADDR: begin
            arb_awaddr  = lsu_awaddr;
            arb_awvalid = lsu_awvalid & ~aw_done_q;
            lsu_awready = arb_awready & ~aw_done_q;
            arb_wdata   = lsu_wdata;
            arb_wstrb   = lsu_wstrb;
            arb_wvalid  = lsu_wvalid & ~w_done_q;
            lsu_wready  = arb_wready & ~w_done_q;
            aw_fire     = lsu_awvalid & ~aw_done_q & arb_awready;
            w_fire      = lsu_wvalid & ~w_done_q & arb_wready;
            if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WR_RESP;
            end else begin
               aw_done_d = aw_done_q | aw_fire;
               w_done_d  = w_done_q | w_fire;
            end
         end

         WR_RESP: begin
            lsu_bresp  = arb_bresp;
            lsu_bvalid = arb_bvalid;
            arb_bready = lsu_bready;
            if (arb_bvalid && lsu_bready) begin
               last_d  = M_LSU;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: vector table plus hand sequences, responses scored through a queue.
module tb_axi_lite_arbiter;
   import axi_lite_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef struct {
      master_e     m;
      logic        is_b;
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   typedef struct {
      logic        wr;
      master_e     m;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      int          lat_a;
      int          lat_b;
   } vec_t;

   logic clk, rst;
   logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata;
   logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
   logic [31:0] ifu_rdata, lsu_rdata;
   logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp;
   logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
   logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
   logic [3:0]  lsu_wstrb, arb_wstrb;
   logic [31:0] arb_araddr, arb_awaddr, arb_wdata, arb_rdata;
   logic        arb_arvalid, arb_arready, arb_rvalid, arb_rready;
   logic        arb_awvalid, arb_awready, arb_wvalid, arb_wready, arb_bvalid, arb_bready;
   logic [1:0]  arb_rresp, arb_bresp;

   int   pass_cnt = 0;
   int   total_cnt = 0;
   exp_t sb_q[$];
   vec_t vecs[6];

   axi_lite_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
      .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
      .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
      .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
      .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
      .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
      .arb_araddr(arb_araddr), .arb_arvalid(arb_arvalid), .arb_arready(arb_arready),
      .arb_rdata(arb_rdata), .arb_rresp(arb_rresp), .arb_rvalid(arb_rvalid), .arb_rready(arb_rready),
      .arb_awaddr(arb_awaddr), .arb_awvalid(arb_awvalid), .arb_awready(arb_awready),
      .arb_wdata(arb_wdata), .arb_wstrb(arb_wstrb), .arb_wvalid(arb_wvalid), .arb_wready(arb_wready),
      .arb_bresp(arb_bresp), .arb_bvalid(arb_bvalid), .arb_bready(arb_bready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [11:0] ctrl_vec();
      return {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
              lsu_bvalid, arb_arvalid, arb_awvalid, arb_wvalid, arb_rready, arb_bready};
   endfunction

   function automatic logic data_or();
      return |{ifu_rdata, ifu_rresp, lsu_rdata, lsu_rresp, lsu_bresp,
               arb_araddr, arb_awaddr, arb_wdata, arb_wstrb};
   endfunction

   task automatic sb_check(input master_e m, input logic is_b, input logic [31:0] d, input logic [1:0] r);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_unexpected_resp", 32'd1, 32'd0);
         return;
      end
      e = sb_q.pop_front();
      chk("sb_master", 32'(m), 32'(e.m));
      chk("sb_kind", 32'(is_b), 32'(e.is_b));
      chk("sb_data", d, e.data);
      chk("sb_resp", 32'(r), 32'(e.resp));
   endtask

   // Response monitor: every master-side response handshake is scored against the queue.
   always @(negedge clk) begin
      #2;
      if (rst) begin
         if (ifu_rvalid && ifu_rready) sb_check(M_IFU, 1'b0, ifu_rdata, ifu_rresp);
         if (lsu_rvalid && lsu_rready) sb_check(M_LSU, 1'b0, lsu_rdata, lsu_rresp);
         if (lsu_bvalid && lsu_bready) sb_check(M_LSU, 1'b1, 32'h0, lsu_bresp);
      end
   end

   task automatic do_read(input master_e m, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input int ar_lat, input int r_lat, input int exp_wait);
      int n;
      n = 1;
      @(negedge clk);
      while (!arb_arvalid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ar_latency", 32'(n), 32'(exp_wait));
      chk("araddr", arb_araddr, addr);
      for (int i = 0; i < ar_lat; i++) begin
         chk("ar_hold", 32'(arb_arvalid), 32'd1);
         @(negedge clk);
      end
      arb_arready = 1'b1;
      #1;
      chk("arready_fwd", 32'(m == M_IFU ? ifu_arready : lsu_arready), 32'd1);
      chk("other_arready", 32'(m == M_IFU ? lsu_arready : ifu_arready), 32'd0);
      @(negedge clk);
      arb_arready = 1'b0;
      if (m == M_IFU) begin
         ifu_arvalid = 1'b0;
         ifu_rready  = 1'b1;
      end else begin
         lsu_arvalid = 1'b0;
         lsu_rready  = 1'b1;
      end
      #1;
      chk("ar_closed", 32'(arb_arvalid), 32'd0);
      chk("rready_fwd", 32'(arb_rready), 32'd1);
      for (int i = 0; i < r_lat; i++) @(negedge clk);
      arb_rvalid = 1'b1;
      arb_rdata  = data;
      arb_rresp  = resp;
      #1;
      chk("other_rvalid", 32'(m == M_IFU ? lsu_rvalid : ifu_rvalid), 32'd0);
      @(negedge clk);
      arb_rvalid = 1'b0;
      arb_rdata  = '0;
      arb_rresp  = '0;
      ifu_rready = 1'b0;
      lsu_rready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] resp, input int aw_lat, input int w_lat, input int exp_wait);
      int n;
      int mx;
      mx = (aw_lat > w_lat) ? aw_lat : w_lat;
      n = 1;
      @(negedge clk);
      while (!arb_awvalid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("aw_latency", 32'(n), 32'(exp_wait));
      chk("awaddr", arb_awaddr, addr);
      chk("wdata", arb_wdata, data);
      chk("wstrb", 32'(arb_wstrb), 32'(strb));
      chk("wr_blocks_ar", 32'({arb_arvalid, lsu_arready, ifu_arready}), 32'd0);
      lsu_bready = 1'b1;
      for (int c = 0; c <= mx; c++) begin
         arb_awready = (c == aw_lat);
         arb_wready  = (c == w_lat);
         #1;
         chk("awvalid_mask", 32'(arb_awvalid), 32'(c <= aw_lat));
         chk("wvalid_mask", 32'(arb_wvalid), 32'(c <= w_lat));
         chk("no_bready_early", 32'(arb_bready), 32'd0);
         @(negedge clk);
      end
      arb_awready = 1'b0;
      arb_wready  = 1'b0;
      lsu_awvalid = 1'b0;
      lsu_wvalid  = 1'b0;
      #1;
      chk("bready_fwd", 32'(arb_bready), 32'd1);
      chk("bvalid_quiet", 32'(lsu_bvalid), 32'd0);
      arb_bvalid = 1'b1;
      arb_bresp  = resp;
      #1;
      chk("bvalid_fwd", 32'(lsu_bvalid), 32'd1);
      @(negedge clk);
      arb_bvalid = 1'b0;
      arb_bresp  = '0;
      lsu_bready = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b0, M_IFU, 32'h8000_0000, 32'hDEAD_BEEF, 4'h0, RESP_OKAY,   2, 0};
      vecs[1] = '{1'b1, M_LSU, 32'hA000_03F8, 32'h0000_0041, 4'h1, RESP_OKAY,   1, 0};
      vecs[2] = '{1'b0, M_LSU, 32'h1000_0010, 32'h1234_5678, 4'h0, RESP_SLVERR, 0, 1};
      vecs[3] = '{1'b0, M_IFU, 32'h8000_0004, 32'h0000_0013, 4'h0, RESP_OKAY,   0, 2};
      vecs[4] = '{1'b1, M_LSU, 32'h2000_0000, 32'hCAFE_F00D, 4'hF, RESP_SLVERR, 0, 2};
      vecs[5] = '{1'b1, M_LSU, 32'h2000_0004, 32'h0BAD_CAFE, 4'h6, RESP_OKAY,   0, 0};

      rst = 1'b0;
      ifu_araddr = '0; lsu_araddr = '0; lsu_awaddr = '0; lsu_wdata = '0; lsu_wstrb = '0;
      lsu_arvalid = 1'b0; lsu_wvalid = 1'b0; lsu_rready = 1'b0;
      arb_rresp = '0; arb_bresp = '0; arb_awready = 1'b0; arb_wready = 1'b0;
      // Garbage on inputs during reset must not leak through.
      ifu_arvalid = 1'b1; lsu_awvalid = 1'b1; arb_rvalid = 1'b1; arb_bvalid = 1'b1;
      arb_rdata = 32'hFFFF_FFFF; ifu_rready = 1'b1; lsu_bready = 1'b1; arb_arready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", 32'(ctrl_vec()), 32'd0);
      chk("rst_data", 32'(data_or()), 32'd0);
      ifu_arvalid = 1'b0; lsu_awvalid = 1'b0; arb_rvalid = 1'b0; arb_bvalid = 1'b0;
      arb_rdata = '0; ifu_rready = 1'b0; lsu_bready = 1'b0; arb_arready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_ctrl", 32'(ctrl_vec()), 32'd0);

      // Contention from reset: IFU first, then IFU re-requests and LSU wins the next tie.
      ifu_araddr = 32'h8000_0100; ifu_arvalid = 1'b1;
      lsu_araddr = 32'h4000_0200; lsu_arvalid = 1'b1;
      sb_q.push_back('{M_IFU, 1'b0, 32'h1111_0001, RESP_OKAY});
      sb_q.push_back('{M_LSU, 1'b0, 32'h2222_0002, RESP_OKAY});
      do_read(M_IFU, 32'h8000_0100, 32'h1111_0001, RESP_OKAY, 0, 0, 1);
      ifu_araddr = 32'h8000_0104; ifu_arvalid = 1'b1;
      sb_q.push_back('{M_IFU, 1'b0, 32'h3333_0003, RESP_OKAY});
      do_read(M_LSU, 32'h4000_0200, 32'h2222_0002, RESP_OKAY, 1, 0, 1);
      do_read(M_IFU, 32'h8000_0104, 32'h3333_0003, RESP_OKAY, 0, 0, 1);

      // LSU write and read requested together: write goes first.
      lsu_awaddr = 32'h3000_0008; lsu_awvalid = 1'b1;
      lsu_wdata = 32'h7777_8888; lsu_wstrb = 4'h3; lsu_wvalid = 1'b1;
      lsu_araddr = 32'h3000_000C; lsu_arvalid = 1'b1;
      sb_q.push_back('{M_LSU, 1'b1, 32'h0, RESP_OKAY});
      sb_q.push_back('{M_LSU, 1'b0, 32'h9999_AAAA, RESP_OKAY});
      do_write(32'h3000_0008, 32'h7777_8888, 4'h3, RESP_OKAY, 1, 1, 1);
      do_read(M_LSU, 32'h3000_000C, 32'h9999_AAAA, RESP_OKAY, 0, 0, 1);

      for (int i = 0; i < 6; i++) begin
         if (vecs[i].wr) begin
            lsu_awaddr = vecs[i].addr; lsu_awvalid = 1'b1;
            lsu_wdata = vecs[i].data; lsu_wstrb = vecs[i].strb; lsu_wvalid = 1'b1;
            sb_q.push_back('{M_LSU, 1'b1, 32'h0, vecs[i].resp});
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp,
                     vecs[i].lat_a, vecs[i].lat_b, 1);
         end else begin
            if (vecs[i].m == M_IFU) begin
               ifu_araddr = vecs[i].addr; ifu_arvalid = 1'b1;
            end else begin
               lsu_araddr = vecs[i].addr; lsu_arvalid = 1'b1;
            end
            sb_q.push_back('{vecs[i].m, 1'b0, vecs[i].data, vecs[i].resp});
            do_read(vecs[i].m, vecs[i].addr, vecs[i].data, vecs[i].resp,
                    vecs[i].lat_a, vecs[i].lat_b, 1);
         end
      end

      // Reset while in RD_DATA with the downstream response held valid.
      ifu_araddr = 32'h8000_0200; ifu_arvalid = 1'b1;
      begin
         int n;
         n = 1;
         @(negedge clk);
         while (!arb_arvalid && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("rst_seq_ar_latency", 32'(n), 32'd1);
      end
      arb_arready = 1'b1;
      @(negedge clk);
      arb_arready = 1'b0;
      ifu_arvalid = 1'b0;
      arb_rvalid = 1'b1; arb_rdata = 32'h5555_AAAA; arb_rresp = RESP_SLVERR;
      #1;
      chk("rd_data_route", 32'(ifu_rvalid), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_ctrl", 32'(ctrl_vec()), 32'd0);
      chk("async_rst_data", 32'(data_or()), 32'd0);
      ifu_rready = 1'b1; lsu_rready = 1'b1; lsu_bready = 1'b1; arb_bvalid = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("post_rst_quiet", 32'(ctrl_vec()), 32'd0);
      end
      arb_rvalid = 1'b0; arb_rdata = '0; arb_rresp = '0; arb_bvalid = 1'b0;
      ifu_rready = 1'b0; lsu_rready = 1'b0; lsu_bready = 1'b0;

      ifu_araddr = 32'h8000_0300; ifu_arvalid = 1'b1;
      sb_q.push_back('{M_IFU, 1'b0, 32'h0F0F_F0F0, RESP_OKAY});
      do_read(M_IFU, 32'h8000_0300, 32'h0F0F_F0F0, RESP_OKAY, 1, 0, 1);

      repeat (2) @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
